// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 scan-code decoder tracking held state of a small key table
module ps2_key_tracker #(
    parameter int NUM_KEYS = 4,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES = {9'h174, 9'h16B, 9'h072, 9'h073},
    parameter int FWD_IDX = 0,
    parameter int BACK_IDX = 1,
    parameter int TIMEOUT_CYCLES = 2500000,
    localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [NUM_KEYS-1:0] key_down,
    output logic                key_event,
    output logic [IW-1:0]       event_index,
    output logic                event_make,
    output logic                seq_error,
    output logic [1:0]          accel
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] EXT     = 2'd1;
    localparam logic [1:0] BRK     = 2'd2;
    localparam logic [1:0] EXT_BRK = 2'd3;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_AA = 8'hAA;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [TW-1:0] tmo_cnt;
    logic          do_lookup;
    logic          lk_ext;
    logic          lk_brk;
    logic          err_now;
    logic          clear_all;
    logic          timed_out;
    logic          hit;
    logic [IW-1:0] hit_idx;

    // Decode the byte stream; a timeout only matters when no byte arrives this cycle.
    always_comb begin
        state_nxt = state;
        do_lookup = 1'b0;
        lk_ext    = 1'b0;
        lk_brk    = 1'b0;
        err_now   = 1'b0;
        clear_all = 1'b0;
        timed_out = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_data == BYTE_E0) begin
                        state_nxt = EXT;
                    end else if (rx_data == BYTE_F0) begin
                        state_nxt = BRK;
                    end else if (rx_data == BYTE_AA) begin
                        clear_all = 1'b1;
                    end else begin
                        do_lookup = 1'b1;
                    end
                end
                EXT: begin
                    if (rx_data == BYTE_F0) begin
                        state_nxt = EXT_BRK;
                    end else if (rx_data != BYTE_E0) begin
                        do_lookup = 1'b1;
                        lk_ext    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                BRK: begin
                    if (rx_data == BYTE_E0) begin
                        state_nxt = EXT;
                        err_now   = 1'b1;
                    end else if (rx_data != BYTE_F0) begin
                        do_lookup = 1'b1;
                        lk_brk    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    if (rx_data == BYTE_E0 || rx_data == BYTE_F0) begin
                        err_now = 1'b1;
                    end else begin
                        do_lookup = 1'b1;
                        lk_ext    = 1'b1;
                        lk_brk    = 1'b1;
                    end
                end
            endcase
        end else if (state != IDLE && tmo_cnt == TMO_MAX) begin
            state_nxt = IDLE;
            err_now   = 1'b1;
            timed_out = 1'b1;
        end
    end

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (KEY_CODES[9*i +: 9] == {lk_ext, rx_data}) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            key_down    <= '0;
            key_event   <= 1'b0;
            event_index <= '0;
            event_make  <= 1'b0;
            seq_error   <= 1'b0;
        end else begin
            state     <= state_nxt;
            seq_error <= err_now;
            key_event <= 1'b0;

            if (rx_valid || state == IDLE || timed_out) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            // Typematic repeats and breaks of unheld keys fall through silently.
            if (clear_all) begin
                key_down <= '0;
            end else if (do_lookup && hit) begin
                if (!lk_brk && !key_down[hit_idx]) begin
                    key_down[hit_idx] <= 1'b1;
                    key_event         <= 1'b1;
                    event_index       <= hit_idx;
                    event_make        <= 1'b1;
                end else if (lk_brk && key_down[hit_idx]) begin
                    key_down[hit_idx] <= 1'b0;
                    key_event         <= 1'b1;
                    event_index       <= hit_idx;
                    event_make        <= 1'b0;
                end
            end
        end
    end

    assign accel = {key_down[FWD_IDX] & ~key_down[BACK_IDX],
                    key_down[BACK_IDX] & ~key_down[FWD_IDX]};

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - scoreboard bench for ps2_key_tracker with directed byte vectors
module tb_ps2_key_tracker;

    localparam int T = 20;

    logic       CLOCK_50;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] key_down;
    logic       key_event;
    logic [1:0] event_index;
    logic       event_make;
    logic       seq_error;
    logic [1:0] accel;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         is_err;
        int         idx;
        bit         make;
        logic [3:0] kd;
        logic [1:0] acc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    ps2_key_tracker #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .key_down   (key_down),
        .key_event  (key_event),
        .event_index(event_index),
        .event_make (event_make),
        .seq_error  (seq_error),
        .accel      (accel)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Monitor: every event or error pulse must match the head of the expectation queue.
    always @(negedge CLOCK_50) begin
        if (reset && (key_event || seq_error)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: event=%0b err=%0b idx=%0d make=%0b kd=%b, required no pulse",
                         key_event, seq_error, event_index, event_make, key_down);
            end else begin
                mon_e = q.pop_front();
                if (key_event != !mon_e.is_err || seq_error != mon_e.is_err ||
                    key_down != mon_e.kd || accel != mon_e.acc ||
                    (!mon_e.is_err && (event_index != mon_e.idx[1:0] || event_make != mon_e.make))) begin
                    errors++;
                    $display("FAIL scoreboard: got event=%0b err=%0b idx=%0d make=%0b kd=%b acc=%b, required event=%0b err=%0b idx=%0d make=%0b kd=%b acc=%b",
                             key_event, seq_error, event_index, event_make, key_down, accel,
                             !mon_e.is_err, mon_e.is_err, mon_e.idx, mon_e.make, mon_e.kd, mon_e.acc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int idx, input bit make, input logic [3:0] kd, input logic [1:0] acc);
        exp_t e;
        e.is_err = 1'b0;
        e.idx    = idx;
        e.make   = make;
        e.kd     = kd;
        e.acc    = acc;
        q.push_back(e);
    endtask

    task automatic push_err(input logic [3:0] kd, input logic [1:0] acc);
        exp_t e;
        e.is_err = 1'b1;
        e.idx    = 0;
        e.make   = 1'b0;
        e.kd     = kd;
        e.acc    = acc;
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge CLOCK_50);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge CLOCK_50);
        rx_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk(name, q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_key_down"}, key_down, 0);
        chk({tag, "_key_event"}, key_event, 0);
        chk({tag, "_event_index"}, event_index, 0);
        chk({tag, "_event_make"}, event_make, 0);
        chk({tag, "_seq_error"}, seq_error, 0);
        chk({tag, "_accel"}, accel, 0);
    endtask

    initial begin
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge CLOCK_50);
        chk_reset_outputs("reset");
        reset = 1'b1;

        // Forward key press/release
        push_ev(0, 1'b1, 4'b0001, 2'b10);
        send(8'h73);
        chk("fwd_press_kd", key_down, 4'b0001);
        chk("fwd_press_accel", accel, 2'b10);
        push_ev(0, 1'b0, 4'b0000, 2'b00);
        send(8'hF0);
        send(8'h73);
        chk("fwd_rel_accel", accel, 2'b00);

        // Extended key with typematic repeat; non-extended code must not match
        push_ev(2, 1'b1, 4'b0100, 2'b00);
        send(8'hE0); send(8'h6B);
        send(8'hE0); send(8'h6B);
        chk("ext_repeat_kd", key_down, 4'b0100);
        push_ev(2, 1'b0, 4'b0000, 2'b00);
        send(8'hE0); send(8'hF0); send(8'h6B);
        send(8'h6B);
        chk("nonext_6b_kd", key_down, 4'b0000);

        // Forward+back interplay
        push_ev(0, 1'b1, 4'b0001, 2'b10);
        send(8'h73);
        push_ev(1, 1'b1, 4'b0011, 2'b00);
        send(8'h72);
        chk("both_accel", accel, 2'b00);
        push_ev(0, 1'b0, 4'b0010, 2'b01);
        send(8'hF0); send(8'h73);
        chk("back_only_accel", accel, 2'b01);
        push_ev(1, 1'b0, 4'b0000, 2'b00);
        send(8'hF0); send(8'h72);

        // Timeout inside an extended sequence
        push_err(4'b0000, 2'b00);
        send(8'hE0);
        drain("timeout_pulse", T + 8);
        chk("hold_event_index", event_index, 1);
        chk("hold_event_make", event_make, 0);
        push_ev(1, 1'b1, 4'b0010, 2'b01);
        send(8'h72);

        // Self-test-passed byte clears everything silently
        push_ev(0, 1'b1, 4'b0011, 2'b00);
        send(8'h73);
        send(8'hAA);
        chk("aa_kd", key_down, 4'b0000);
        chk("aa_accel", accel, 2'b00);

        // Reset mid-sequence discards the pending E0 F0
        push_ev(0, 1'b1, 4'b0001, 2'b10);
        send(8'h73);
        send(8'hE0); send(8'hF0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        chk_reset_outputs("midseq_reset");
        reset = 1'b1;
        push_ev(0, 1'b1, 4'b0001, 2'b10);
        send(8'h73);
        drain("post_reset_make", 4);

        // Malformed sequences
        push_err(4'b0001, 2'b10);
        send(8'hF0); send(8'hE0);
        push_ev(2, 1'b1, 4'b0101, 2'b10);
        send(8'h6B);
        push_err(4'b0101, 2'b10);
        send(8'hE0); send(8'hF0); send(8'hE0);
        push_err(4'b0101, 2'b10);
        send(8'hE0); send(8'hF0); send(8'hF0);
        send(8'h6B);
        chk("after_malformed_kd", key_down, 4'b0101);

        drain("final_queue_empty", 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 Parameter NUM_KEYS, default 4, meaning number of tracked keys, legal range 1..16.
REQ-002 Parameter KEY_CODES, default {9'h174, 9'h16B, 9'h072, 9'h073}, meaning packed NUM_KEYS x 9-bit table; entry i = KEY_CODES[9i+8:9i], bit 8 = E0-extended flag, bits 7:0 = scan code.
REQ-003 Parameter FWD_IDX, default 0, meaning key index driving forward acceleration.
REQ-004 Parameter BACK_IDX, default 1, meaning key index driving backward acceleration; must differ from FWD_IDX.
REQ-005 Parameter TIMEOUT_CYCLES, default 2500000, meaning maximum idle cycles allowed inside a multi-byte sequence.
REQ-006 CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 rx_data  in  8  received PS/2 byte, valid only while rx_valid=1.
REQ-009 rx_valid  in  1  one-cycle strobe per received byte.
REQ-010 key_down  out  NUM_KEYS  bit i = 1 while key i is held.
REQ-011 key_event  out  1  one-cycle pulse on a held-state change of a tracked key.
REQ-012 event_index  out  IW  index of the changed key; IW = max(1, clog2(NUM_KEYS)).
REQ-013 event_make  out  1  1 = press, 0 = release; qualified by key_event.
REQ-014 seq_error  out  1  one-cycle pulse on sequence timeout or malformed sequence.
REQ-015 accel  out  2  2'b10 forward, 2'b01 backward, 2'b00 coast.

Function
REQ-016 The decoder SHALL be an FSM with states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), advancing only on rx_valid=1.
REQ-017 IDLE: E0 -> EXT; F0 -> BRK; AA -> clear all key_down with no events, stay IDLE; any other byte -> make lookup (ext=0), stay IDLE.
REQ-018 EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> make lookup (ext=1), go IDLE.
REQ-019 BRK: E0 -> EXT with a seq_error pulse; F0 -> stay BRK; other -> break lookup (ext=0), go IDLE.
REQ-020 EXT_BRK: E0 or F0 -> IDLE with a seq_error pulse; other -> break lookup (ext=1), go IDLE.
REQ-021 A lookup SHALL compare {ext, byte} against all table entries in parallel; the lowest matching index wins; no match means no action.
REQ-022 A make of key i with key_down[i]=0 SHALL set key_down[i] and pulse key_event with event_make=1 and event_index=i.
REQ-023 A make of key i already held (typematic repeat) SHALL produce no event and no change.
REQ-024 A break of key i with key_down[i]=1 SHALL clear key_down[i] and pulse key_event with event_make=0; a break of an unheld key SHALL produce nothing.
REQ-025 Latency: key_down, key_event, event_index, event_make and seq_error SHALL update on the rising edge following the final byte's rx_valid cycle, i.e. 1 cycle.
REQ-026 event_index and event_make SHALL hold their last values while key_event=0.
REQ-027 A timeout counter SHALL clear on every rx_valid and count while the FSM is outside IDLE; on reaching TIMEOUT_CYCLES-1 without rx_valid, the FSM SHALL go to IDLE, pulse seq_error, and leave key_down unchanged.
REQ-028 accel SHALL equal 2'b10 when only key_down[FWD_IDX] is set, 2'b01 when only key_down[BACK_IDX] is set, and 2'b00 when both or neither are set, in the same cycle as key_down.
REQ-029 At most one key_event pulse SHALL occur per rx_valid byte.

Reset
REQ-030 While reset=0 at a rising edge: FSM=IDLE, timeout counter=0, key_down=0, key_event=0, event_index=0, event_make=0, seq_error=0, accel=2'b00.
REQ-031 Reset asserted mid-sequence (e.g. after E0) SHALL discard the partial sequence; the next byte after release SHALL be decoded from IDLE.

Verification
REQ-032 Bytes 73, F0 73 -> key_down[0] rises with event(idx0, make), accel=10; after F0 73, key_down[0] falls with event(idx0, break), accel=00.
REQ-033 Bytes E0 6B, E0 6B, E0 F0 6B -> exactly one make event for idx2, no repeat event, then one break event for idx2; non-extended 6B alone -> no event.
REQ-034 Press 73 then 72 -> accel 10 then 00; release 73 -> accel 01.
REQ-035 E0, then TIMEOUT_CYCLES idle cycles -> seq_error pulse, FSM back in IDLE; a following 72 -> make event for idx1.
REQ-036 With idx0 and idx1 held, byte AA -> key_down=0, accel=00, no key_event; reset=0 applied after E0 F0 -> all outputs at reset values.
